// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 command controller: FSM encoding and
// phrase-table geometry.
package jt6295_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CH = 2'd1,
    FETCH   = 2'd2,
    ISSUE   = 2'd3
  } ctrl_state_t;

  // Each phrase-table entry occupies 8 bytes; only the first six are read.
  localparam logic [17:0] ENTRY_BYTES = 18'd8;
  localparam logic [2:0]  LAST_IDX    = 3'd5;

  function automatic logic [17:0] entry_addr(input logic [6:0] phrase,
                                             input logic [2:0] idx);
    return ({11'd0, phrase} * ENTRY_BYTES) + {15'd0, idx};
  endfunction

endpackage

// File: rtl/jt6295_ctrl.sv
// jt6295 CPU command decoder: phrase/channel writes, phrase-table fetch,
// per-channel start/stop pulses and the status byte.
module jt6295_ctrl
  import jt6295_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrn,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [3:0]  busy,
  output logic [17:0] start_addr,
  output logic [17:0] stop_addr,
  output logic [3:0]  att,
  output logic [3:0]  start,
  output logic [3:0]  stop,
  output logic [17:0] rom_addr,
  output logic        rom_cs,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  ctrl_state_t state_r, state_s;
  logic [2:0]  idx_r, idx_s;
  logic [6:0]  phrase_r, phrase_s;
  logic [3:0]  mask_r, mask_s;
  logic [3:0]  att_pend_r, att_pend_s;
  logic        hold_r, hold_s;
  logic        got_r, got_s;
  logic [17:0] sa_r, sa_s;
  logic [9:0]  ea_r, ea_s;
  logic [17:0] addr_s, saddr_s, eaddr_s;
  logic        cs_s;
  logic [3:0]  att_s, start_s, stop_s;
  logic        wr_s;

  assign wr_s = ~wrn;

  // Next-state and next-output logic
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    phrase_s   = phrase_r;
    mask_s     = mask_r;
    att_pend_s = att_pend_r;
    hold_s     = hold_r;
    got_s      = got_r;
    sa_s       = sa_r;
    ea_s       = ea_r;
    addr_s     = rom_addr;
    cs_s       = rom_cs;
    saddr_s    = start_addr;
    eaddr_s    = stop_addr;
    att_s      = att;
    start_s    = 4'd0;
    // Stop commands act in every state except WAIT_CH, where the byte is a channel write.
    stop_s     = (wr_s && !din[7] && (state_r != WAIT_CH)) ? din[6:3] : 4'd0;
    case (state_r)
      IDLE: begin
        if (wr_s && din[7]) begin
          phrase_s = din[6:0];
          state_s  = WAIT_CH;
        end else begin
          state_s  = IDLE;
        end
      end
      WAIT_CH: begin
        if (wr_s) begin
          mask_s     = din[7:4];
          att_pend_s = din[3:0];
          if (phrase_r == 7'd0) begin
            state_s = IDLE;
          end else begin
            state_s = FETCH;
            idx_s   = 3'd0;
            addr_s  = entry_addr(phrase_r, 3'd0);
            cs_s    = 1'b1;
            hold_s  = 1'b1;
            got_s   = 1'b0;
          end
        end else begin
          state_s = WAIT_CH;
        end
      end
      FETCH: begin
        // hold_r masks rom_ok on the cycle the address moves; got_r is the advance cycle.
        if (hold_r) begin
          hold_s = 1'b0;
        end else if (got_r) begin
          idx_s  = idx_r + 3'd1;
          addr_s = entry_addr(phrase_r, idx_r + 3'd1);
          hold_s = 1'b1;
          got_s  = 1'b0;
        end else if (rom_ok) begin
          got_s = 1'b1;
          case (idx_r)
            3'd0:    sa_s[17:16] = rom_data[1:0];
            3'd1:    sa_s[15:8]  = rom_data;
            3'd2:    sa_s[7:0]   = rom_data;
            3'd3:    ea_s[9:8]   = rom_data[1:0];
            3'd4:    ea_s[7:0]   = rom_data;
            default: begin
              got_s   = 1'b0;
              state_s = ISSUE;
              cs_s    = 1'b0;
              idx_s   = 3'd0;
              saddr_s = sa_r;
              eaddr_s = {ea_r, rom_data};
              att_s   = att_pend_r;
            end
          endcase
        end else begin
          got_s = 1'b0;
        end
      end
      ISSUE: begin
        start_s = mask_r & ~busy;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Command context, fetch bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r      <= 3'd0;
      phrase_r   <= 7'd0;
      mask_r     <= 4'd0;
      att_pend_r <= 4'd0;
      hold_r     <= 1'b0;
      got_r      <= 1'b0;
      sa_r       <= 18'd0;
      ea_r       <= 10'd0;
      rom_addr   <= 18'd0;
      rom_cs     <= 1'b0;
      start_addr <= 18'd0;
      stop_addr  <= 18'd0;
      att        <= 4'd0;
      start      <= 4'd0;
      stop       <= 4'd0;
    end else begin
      idx_r      <= idx_s;
      phrase_r   <= phrase_s;
      mask_r     <= mask_s;
      att_pend_r <= att_pend_s;
      hold_r     <= hold_s;
      got_r      <= got_s;
      sa_r       <= sa_s;
      ea_r       <= ea_s;
      rom_addr   <= addr_s;
      rom_cs     <= cs_s;
      start_addr <= saddr_s;
      stop_addr  <= eaddr_s;
      att        <= att_s;
      start      <= start_s;
      stop       <= stop_s;
    end
  end

  // Status readback
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= 8'd0;
    end else begin
      dout <= {4'b0000, busy};
    end
  end

endmodule

// File: tb/tb_jt6295_ctrl.sv
// Self-checking bench for jt6295_ctrl: vector table, directed corner cases and
// randomized commands checked against a phrase-table reference model.
module tb_jt6295_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, wrn, rom_cs, rom_ok;
  logic [7:0]  din, dout, rom_data;
  logic [3:0]  busy, att, start, stop;
  logic [17:0] start_addr, stop_addr, rom_addr;

  jt6295_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wrn(wrn), .din(din), .dout(dout), .busy(busy),
    .start_addr(start_addr), .stop_addr(stop_addr), .att(att), .start(start),
    .stop(stop), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .rom_ok(rom_ok)
  );

  always #5 clk = ~clk;

  // ROM model: garbage data (and rom_ok when glitch=1) on the address-change
  // cycle, then rom_ok after lat further cycles.
  logic [7:0]  rom [0:1023];
  logic [17:0] last_addr = 18'd0;
  int          since = 0;
  int          lat = 0;
  bit          glitch = 1'b0;
  int          pass_cnt = 0;
  int          chk_cnt = 0;

  always @(posedge clk) begin
    since     <= (rom_addr != last_addr) ? 0 : since + 1;
    last_addr <= rom_addr;
  end
  assign rom_ok   = rom_cs && ((rom_addr != last_addr) ? glitch : (since >= lat));
  assign rom_data = (rom_addr != last_addr) ? 8'h5A : rom[rom_addr[9:0]];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    wrn = 1'b0;
    din = d;
    @(negedge clk);
    wrn = 1'b1;
  endtask

  // Issue phrase byte d1 and channel byte d2, optionally inject a write at
  // monitor cycle inj_at, and collect pulses until the fetch has finished.
  task automatic do_cmd(input string tag, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [3:0] bz, input int l, input bit g,
                        input int inj_at, input logic [7:0] inj,
                        output logic [3:0] st_or, output int st_cnt,
                        output logic [3:0] sp_or, output int sp_cnt);
    logic [17:0] addrs[$];
    int post;
    int bad;
    bit seen;
    busy = bz; lat = l; glitch = g;
    st_or = 4'd0; st_cnt = 0; sp_or = 4'd0; sp_cnt = 0; post = 0; seen = 1'b0;
    wr(d1);
    wr(d2);
    for (int c = 0; c < 500 && post < 4; c++) begin
      @(negedge clk);
      if (rom_cs && (addrs.size() == 0 || addrs[$] != rom_addr)) addrs.push_back(rom_addr);
      if (start != 4'd0) begin st_or |= start; st_cnt++; end
      if (stop != 4'd0) begin sp_or |= stop; sp_cnt++; end
      if (rom_cs) seen = 1'b1;
      else if (seen) post++;
      wrn = (c == inj_at) ? 1'b0 : 1'b1;
      din = inj;
    end
    wrn = 1'b1;
    check({tag, "_done"}, 80'(post), 80'd4);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (i >= addrs.size() || addrs[i] != 18'(int'(d1[6:0]) * 8 + i)) bad++;
    check({tag, "_addr_cnt"}, 80'(addrs.size()), 80'd6);
    check({tag, "_addr_seq"}, 80'(bad), 80'd0);
  endtask

  typedef struct {
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [3:0]  bz;
    int          l;
    bit          g;
    logic [3:0]  e_start;
    logic [3:0]  e_att;
    logic [17:0] e_sa;
    logic [17:0] e_ea;
  } vec_t;

  initial begin
    vec_t        vt [4];
    logic [3:0]  st_or, sp_or, m, a, bz, e_start;
    int          st_cnt, sp_cnt, bad, base;
    logic [6:0]  p;
    bit          found;

    vt[0] = '{8'h81, 8'h13, 4'b0000, 0, 1'b1, 4'b0001, 4'h3, 18'h01000, 18'h01FFF};
    vt[1] = '{8'h82, 8'hF0, 4'b0101, 2, 1'b0, 4'b1010, 4'h0, 18'h2ABCD, 18'h11234};
    vt[2] = '{8'h83, 8'hFA, 4'b1111, 1, 1'b1, 4'b0000, 4'hA, 18'h3FFFF, 18'h00000};
    vt[3] = '{8'h81, 8'h2C, 4'b0000, 3, 1'b0, 4'b0010, 4'hC, 18'h01000, 18'h01FFF};

    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[8]  = 8'h00; rom[9]  = 8'h10; rom[10] = 8'h00;
    rom[11] = 8'h00; rom[12] = 8'h1F; rom[13] = 8'hFF;
    rom[16] = 8'hFE; rom[17] = 8'hAB; rom[18] = 8'hCD;
    rom[19] = 8'h7D; rom[20] = 8'h12; rom[21] = 8'h34;
    rom[24] = 8'h03; rom[25] = 8'hFF; rom[26] = 8'hFF;
    rom[27] = 8'h00; rom[28] = 8'h00; rom[29] = 8'h00;

    rst_n = 1'b0; wrn = 1'b1; din = 8'h00; busy = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          80'({start_addr, stop_addr, att, start, stop, rom_addr, rom_cs, dout}), 80'd0);
    rst_n = 1'b1;

    // Status byte follows busy one cycle later
    @(negedge clk);
    busy = 4'hA;
    check("dout_before", 80'(dout), 80'h00);
    @(negedge clk);
    check("dout_after", 80'(dout), 80'h0A);
    busy = 4'd0;

    // Stop command in IDLE
    wr(8'h78);
    check("stop_pulse", 80'(stop), 80'hF);
    @(negedge clk);
    check("stop_clear", 80'(stop), 80'h0);

    for (int i = 0; i < 4; i++) begin
      do_cmd($sformatf("vec%0d", i), vt[i].d1, vt[i].d2, vt[i].bz, vt[i].l, vt[i].g,
             -1, 8'h00, st_or, st_cnt, sp_or, sp_cnt);
      check($sformatf("vec%0d_start", i), 80'(st_or), 80'(vt[i].e_start));
      check($sformatf("vec%0d_pulses", i), 80'(st_cnt), (vt[i].e_start != 4'd0) ? 80'd1 : 80'd0);
      check($sformatf("vec%0d_saddr", i), 80'(start_addr), 80'(vt[i].e_sa));
      check($sformatf("vec%0d_eaddr", i), 80'(stop_addr), 80'(vt[i].e_ea));
      check($sformatf("vec%0d_att", i), 80'(att), 80'(vt[i].e_att));
    end

    // Phrase 0: no fetch, straight back to IDLE (a following stop byte acts as stop)
    wr(8'h80);
    wr(8'hF0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (rom_cs || start != 4'd0) bad++;
    end
    check("p0_quiet", 80'(bad), 80'd0);
    wr(8'h08);
    check("p0_idle_stop", 80'(stop), 80'h1);

    // Phrase write during a slow fetch is discarded
    do_cmd("inj85", 8'h82, 8'h51, 4'b0000, 5, 1'b0, 10, 8'h85, st_or, st_cnt, sp_or, sp_cnt);
    check("inj85_start", 80'(st_or), 80'h5);
    check("inj85_saddr", 80'(start_addr), 80'h2ABCD);
    check("inj85_eaddr", 80'(stop_addr), 80'h11234);
    check("inj85_att", 80'(att), 80'h1);
    check("inj85_nostop", 80'(sp_cnt), 80'd0);

    // Stop write during a fetch executes at once without disturbing it
    do_cmd("injstop", 8'h83, 8'h30, 4'b0000, 2, 1'b1, 8, 8'h40, st_or, st_cnt, sp_or, sp_cnt);
    check("injstop_start", 80'(st_or), 80'h3);
    check("injstop_saddr", 80'(start_addr), 80'h3FFFF);
    check("injstop_eaddr", 80'(stop_addr), 80'h00000);
    check("injstop_stop", 80'(sp_or), 80'h8);
    check("injstop_stopcnt", 80'(sp_cnt), 80'd1);

    // Randomized commands against the phrase-table model
    for (int n = 0; n < 20; n++) begin
      p  = 7'($urandom_range(4, 127));
      m  = 4'($urandom);
      a  = 4'($urandom);
      bz = 4'($urandom);
      do_cmd("rnd", {1'b1, p}, {m, a}, bz, int'($urandom_range(0, 4)), 1'($urandom),
             -1, 8'h00, st_or, st_cnt, sp_or, sp_cnt);
      e_start = m & ~bz;
      base    = int'(p) * 8;
      check("rnd_start", 80'(st_or), 80'(e_start));
      check("rnd_pulses", 80'(st_cnt), (e_start != 4'd0) ? 80'd1 : 80'd0);
      check("rnd_saddr", 80'(start_addr), 80'({rom[base][1:0], rom[base+1], rom[base+2]}));
      check("rnd_eaddr", 80'(stop_addr), 80'({rom[base+3][1:0], rom[base+4], rom[base+5]}));
      check("rnd_att", 80'(att), 80'(a));
    end

    // Reset while fetching byte 3 abandons the command
    busy = 4'd0; lat = 3; glitch = 1'b0;
    wr(8'h82);
    wr(8'h3F);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (rom_cs && rom_addr == 18'd19) found = 1'b1;
    end
    check("rst_reach_idx3", 80'(found), 80'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs",
          80'({start_addr, stop_addr, att, start, stop, rom_addr, rom_cs, dout}), 80'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rom_cs || start != 4'd0) bad++;
    end
    check("rst_no_start", 80'(bad), 80'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/jt6295_ctrl.md
JT6295_CTRL -- requirements
Module: jt6295_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 wrn  in  1  CPU write strobe, active low; one command byte per cycle while low.
REQ-005 din  in  8  CPU command byte, sampled when wrn=0.
REQ-006 dout  out  8  status byte {4'b0000, busy}, registered.
REQ-007 busy  in  4  per-channel busy flags from the serializer stage.
REQ-008 start_addr  out  18  phrase start address presented to the serializer.
REQ-009 stop_addr  out  18  phrase stop address presented to the serializer.
REQ-010 att  out  4  attenuation for the started channels.
REQ-011 start  out  4  one-clk per-channel start pulse.
REQ-012 stop  out  4  one-clk per-channel stop pulse.
REQ-013 rom_addr  out  18  phrase-table read address.
REQ-014 rom_cs  out  1  ROM read request, held until the byte is accepted.
REQ-015 rom_data  in  8  ROM read data.
REQ-016 rom_ok  in  1  rom_data is valid for the current rom_addr.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_CH, FETCH, ISSUE.
REQ-018 IDLE, write with din[7]=1: latch phrase=din[6:0]; go to WAIT_CH.
REQ-019 IDLE, write with din[7]=0: pulse stop=din[6:3] on the next cycle; stay in IDLE.
REQ-020 WAIT_CH, any write: latch mask=din[7:4] and att=din[3:0], regardless of din[7]. Go to FETCH. If phrase=0, go to IDLE instead, with no ROM access.
REQ-021 FETCH: read six bytes, idx 0..5, at rom_addr = zero-extended {phrase,3'b000}+idx. Keep rom_cs=1.
REQ-022 Per-byte handshake: ignore rom_ok on the cycle rom_addr changes. Capture rom_data on the first later cycle with rom_ok=1. Advance idx on the next cycle.
REQ-023 Address assembly: start_addr={b0[1:0],b1,b2}; stop_addr={b3[1:0],b4,b5}. Upper bits of b0/b3 are discarded.
REQ-024 After byte 5 is captured: rom_cs drops; state goes to ISSUE.
REQ-025 ISSUE lasts one cycle: start=mask & ~busy, then return to IDLE.
REQ-026 start_addr, stop_addr and att SHALL be updated before the start pulse and held until the next ISSUE.
REQ-027 Stop writes (din[7]=0) during FETCH or ISSUE SHALL execute immediately per REQ-019, without disturbing the fetch.
REQ-028 Phrase writes (din[7]=1) during FETCH or ISSUE SHALL be discarded.
REQ-029 If stop and start target the same channel in the same cycle, both pulses SHALL be output; the serializer resolves them.
REQ-030 start and stop SHALL be 4'b0 on every cycle other than the ones defined above.
REQ-031 Latency: dout SHALL reflect busy one cycle later.

Reset
REQ-032 While rst_n=0 the block SHALL drive:
- state=IDLE, idx=0, phrase=0, mask=0
- start=0, stop=0, rom_cs=0, rom_addr=0
- start_addr=0, stop_addr=0, att=0, dout=0
REQ-033 Reset mid-FETCH SHALL abandon the command and emit no start pulse.

Structure
REQ-034 The FSM state encoding and the phrase-table entry size constant (8 bytes) SHALL be placed in the shared jt6295 package.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 Write 0x81, then 0x13. ROM 8..13 = 00 10 00 00 1F FF. Expected: rom_addr sequence 8..13; start_addr=0x01000, stop_addr=0x01FFF, att=3, start=4'b0001 for one clk.
REQ-037 Write 0x80, then 0xF0. Expected: no rom_cs, no start pulse, return to IDLE.
REQ-038 Write 0x78 in IDLE. Expected: stop=4'b1111 for one clk.
REQ-039 Issue phrase 2 with mask 0xF0 while busy=4'b0101. Expected: start=4'b1010.
REQ-040 Hold rom_ok=0 for 5 cycles on each byte while writing 0x85 mid-FETCH. Expected: rom_addr holds; 0x85 is ignored; addresses are correct.
REQ-041 Pull rst_n low on FETCH idx=3. Expected: all outputs zero next cycle; no start pulse afterwards.
